// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing controller between pipeline stage 3 and the shared multi-cycle FPU.
// Holds one op at a time, exports a pending-destination scoreboard and a one-cycle writeback.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNTW    = 7,
  parameter logic [15:0] NAN_VAL = 16'h7fc0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [3:0]  req_dest_i,
  input  logic        req_setz_i,
  input  logic [15:0] req_a_i,
  input  logic [15:0] req_b_i,
  input  logic        kill_i,
  output logic        fpu_start_o,
  output logic [2:0]  fpu_op_o,
  output logic [15:0] fpu_a_o,
  output logic [15:0] fpu_b_o,
  input  logic        fpu_done_i,
  input  logic [15:0] fpu_result_i,
  output logic        wb_valid_o,
  output logic [3:0]  wb_dest_o,
  output logic [15:0] wb_data_o,
  output logic        z_valid_o,
  output logic        z_value_o,
  output logic        pend_valid_o,
  output logic [3:0]  pend_dest_o,
  output logic        frz_o,
  output logic        err_o
);

  localparam int unsigned OPW  = 3;
  localparam int unsigned REGW = 4;
  localparam int unsigned DW   = 16;
  localparam logic [OPW-1:0]  LAST_LEGAL_OP = OPW'(5);
  localparam logic [CNTW-1:0] CNT_LAST      = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic [REGW-1:0]   dest_q, dest_d;
  logic              setz_q, setz_d;
  logic              drop_q, drop_d;
  logic              start_q, start_d;
  logic              wbv_q, wbv_d;
  logic [REGW-1:0]   wb_dest_q, wb_dest_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;
  logic              zv_q, zv_d;
  logic              zval_q, zval_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;

  logic              fin;
  logic              fin_bad;
  logic              drop_now;
  logic [DW-1:0]     fin_data;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dest_d    = dest_q;
    setz_d    = setz_q;
    drop_d    = drop_q;
    start_d   = 1'b0;
    wbv_d     = 1'b0;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    zv_d      = 1'b0;
    zval_d    = zval_q;
    pend_d    = pend_q;
    err_d     = err_q;
    fin       = 1'b0;
    fin_bad   = 1'b0;
    fin_data  = NAN_VAL;
    drop_now  = drop_q | kill_i;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d   = req_op_i;
          a_d    = req_a_i;
          b_d    = req_b_i;
          dest_d = req_dest_i;
          setz_d = req_setz_i;
          pend_d = 1'b1;
          drop_d = 1'b0;
          if (req_op_i <= LAST_LEGAL_OP) begin
            state_d = S_ISSUE;
            start_d = 1'b1;
          end else begin
            // Illegal op bypasses the FPU and writes back NaN directly
            state_d   = S_WB;
            wbv_d     = 1'b1;
            wb_dest_d = req_dest_i;
            wb_data_d = NAN_VAL;
            zval_d    = (NAN_VAL == '0);
            zv_d      = req_setz_i;
            err_d     = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        drop_d  = drop_now;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        drop_d = drop_now;
        if (fpu_done_i) begin
          fin      = 1'b1;
          fin_data = fpu_result_i;
        end else if (cnt_q == CNT_LAST) begin
          fin     = 1'b1;
          fin_bad = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
        if (fin) begin
          state_d   = S_WB;
          wbv_d     = ~drop_now;
          zv_d      = setz_q & ~drop_now;
          wb_dest_d = dest_q;
          wb_data_d = fin_data;
          zval_d    = (fin_data == '0);
          err_d     = err_q | (fin_bad & ~drop_now);
        end
      end
      S_WB: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dest_q    <= '0;
      setz_q    <= 1'b0;
      drop_q    <= 1'b0;
      start_q   <= 1'b0;
      wbv_q     <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      zv_q      <= 1'b0;
      zval_q    <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
      setz_q    <= setz_d;
      drop_q    <= drop_d;
      start_q   <= start_d;
      wbv_q     <= wbv_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      zv_q      <= zv_d;
      zval_q    <= zval_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign fpu_start_o  = start_q;
  assign fpu_op_o     = op_q;
  assign fpu_a_o      = a_q;
  assign fpu_b_o      = b_q;
  // A flush arriving during the writeback cycle itself still has to squash the strobe
  assign wb_valid_o   = wbv_q & ~kill_i;
  assign z_valid_o    = zv_q & ~kill_i;
  assign wb_dest_o    = wb_dest_q;
  assign wb_data_o    = wb_data_q;
  assign z_value_o    = zval_q;
  assign pend_valid_o = pend_q;
  assign pend_dest_o  = dest_q;
  assign frz_o        = pend_q;
  assign err_o        = err_q;

endmodule
